// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: widths, float fields, angle table, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package cordic_pkg;

    localparam int CORDIC_M  = 22;
    localparam int W         = 32;
    localparam int FIXED_W   = 26;
    localparam int INT_W     = 28;
    localparam int ANG_W     = 27;
    localparam int CNT_W     = 5;
    localparam int FRAC_BITS = 24;

    localparam int FLT_BIAS = 127;
    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MANT_HI  = 22;
    localparam int MANT_LO  = 0;

    localparam logic signed [ANG_W-1:0] PI_HALF     = 27'sd26353589;
    localparam logic signed [ANG_W-1:0] NEG_PI_HALF = -27'sd26353589;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_PACK
    } state_t;

    // atan(2^-i) scaled by 2^24, rounded to nearest
    function automatic logic signed [ANG_W-1:0] atan_lut(input logic [CNT_W-1:0] i);
        case (i)
            5'd0:    atan_lut = 27'sd13176795;
            5'd1:    atan_lut = 27'sd7778716;
            5'd2:    atan_lut = 27'sd4110061;
            5'd3:    atan_lut = 27'sd2086331;
            5'd4:    atan_lut = 27'sd1047214;
            5'd5:    atan_lut = 27'sd524117;
            5'd6:    atan_lut = 27'sd262123;
            5'd7:    atan_lut = 27'sd131069;
            5'd8:    atan_lut = 27'sd65536;
            5'd9:    atan_lut = 27'sd32768;
            5'd10:   atan_lut = 27'sd16384;
            5'd11:   atan_lut = 27'sd8192;
            5'd12:   atan_lut = 27'sd4096;
            5'd13:   atan_lut = 27'sd2048;
            5'd14:   atan_lut = 27'sd1024;
            5'd15:   atan_lut = 27'sd512;
            5'd16:   atan_lut = 27'sd256;
            5'd17:   atan_lut = 27'sd128;
            5'd18:   atan_lut = 27'sd64;
            5'd19:   atan_lut = 27'sd32;
            5'd20:   atan_lut = 27'sd16;
            5'd21:   atan_lut = 27'sd8;
            5'd22:   atan_lut = 27'sd4;
            5'd23:   atan_lut = 27'sd2;
            default: atan_lut = '0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_vectoring_if.sv
// Start/done handshake bundle for the vectoring CORDIC custom instruction.
// No latency of its own; the unit never stalls its consumer, start is dropped while busy.
interface cordic_vectoring_if;
    import cordic_pkg::*;

    logic             start;
    logic [W-1:0]     dataa;
    logic [W-1:0]     datab;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic [ANG_W-1:0] fixedpoint_out;

    modport master (
        output start, dataa, datab,
        input  busy, done, result, fixedpoint_out
    );

    modport slave (
        input  start, dataa, datab,
        output busy, done, result, fixedpoint_out
    );
endinterface

// File: rtl/float_to_fixed.sv
// Float32 to signed Q1.24 with saturation at +/-(2-2^-24); zero/denormal and tiny values give 0.
// Combinational, no backpressure.
module float_to_fixed
    import cordic_pkg::*;
(
    input  logic [W-1:0]              f,
    output logic signed [FIXED_W-1:0] q
);

    logic [7:0]         e;
    logic [23:0]        mant;
    logic [7:0]         rsh;
    logic [FIXED_W-2:0] mag;

    always_comb begin
        e    = f[EXP_HI:EXP_LO];
        mant = {1'b1, f[MANT_HI:MANT_LO]};
        rsh  = 8'(FLT_BIAS - 1) - e;
        mag  = '0;
        // Inf/NaN land in the e > bias branch and saturate like any large value
        if (e == 8'd0)
            mag = '0;
        else if (e > 8'(FLT_BIAS))
            mag = '1;
        else if (e == 8'(FLT_BIAS))
            mag = {mant, 1'b0};
        else if (rsh < 8'(FRAC_BITS))
            mag = 25'(mant >> rsh);
        q = f[SIGN_BIT] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: atan2(datab, dataa) in radians as float32, one micro-rotation per clock.
// Latency M+2 clocks from accepted start to done; start is ignored while busy, no output backpressure.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int M = CORDIC_M
) (
    input  logic clk,
    input  logic rst,
    cordic_vectoring_if.slave bus
);

    state_t                    state;
    logic [W-1:0]              a_q, b_q;
    logic signed [FIXED_W-1:0] a_fix, b_fix;
    logic signed [INT_W-1:0]   x_q, y_q;
    logic signed [ANG_W-1:0]   z_q;
    logic [CNT_W-1:0]          cnt;
    logic                      zero_in;
    logic                      busy_q, done_q;
    logic [W-1:0]              result_q;
    logic [ANG_W-1:0]          fixed_q;

    float_to_fixed u_cvt_a (.f(a_q), .q(a_fix));
    float_to_fixed u_cvt_b (.f(b_q), .q(b_fix));

    // Fold into the right half-plane so the iterations only cover +/-pi/2
    logic signed [INT_W-1:0] xa, yb, x0, y0;
    logic signed [ANG_W-1:0] z0;

    always_comb begin
        xa = {{(INT_W-FIXED_W){a_fix[FIXED_W-1]}}, a_fix};
        yb = {{(INT_W-FIXED_W){b_fix[FIXED_W-1]}}, b_fix};
        if (!xa[INT_W-1]) begin
            x0 = xa;
            y0 = yb;
            z0 = '0;
        end else if (!yb[INT_W-1]) begin
            x0 = yb;
            y0 = -xa;
            z0 = PI_HALF;
        end else begin
            x0 = -yb;
            y0 = xa;
            z0 = NEG_PI_HALF;
        end
    end

    logic signed [INT_W-1:0] xs, ys;
    logic signed [ANG_W-1:0] at;

    always_comb begin
        xs = x_q >>> cnt;
        ys = y_q >>> cnt;
        at = atan_lut(cnt);
    end

    logic signed [ANG_W-1:0] z_fin;
    logic [ANG_W-1:0]        z_mag, norm;
    logic [4:0]              lead;
    logic [22:0]             mant_o;
    logic [7:0]              exp_o;
    logic [W-1:0]            flt;

    always_comb begin
        z_fin = zero_in ? '0 : z_q;
        z_mag = z_fin[ANG_W-1] ? -z_fin : z_fin;
        lead  = '0;
        for (int k = 0; k < ANG_W; k++) begin
            if (z_mag[k])
                lead = 5'(k);
        end
        norm   = z_mag << (5'(ANG_W-1) - lead);
        // Hidden one sits at bit ANG_W-1 after normalising; keep the next 23 bits, truncated
        mant_o = 23'(norm >> (ANG_W - 24));
        exp_o  = 8'(FLT_BIAS - FRAC_BITS) + {3'b000, lead};
        flt    = '0;
        if (z_mag != '0)
            flt = {z_fin[ANG_W-1], exp_o, mant_o};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            cnt      <= '0;
            zero_in  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            fixed_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.dataa;
                        b_q    <= bus.datab;
                        busy_q <= 1'b1;
                        state  <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    x_q     <= x0;
                    y_q     <= y0;
                    z_q     <= z0;
                    cnt     <= '0;
                    zero_in <= (a_fix == '0) && (b_fix == '0);
                    state   <= ST_ITER;
                end
                ST_ITER: begin
                    if (!y_q[INT_W-1]) begin
                        x_q <= x_q + ys;
                        y_q <= y_q - xs;
                        z_q <= z_q + at;
                    end else begin
                        x_q <= x_q - ys;
                        y_q <= y_q + xs;
                        z_q <= z_q - at;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(M - 1))
                        state <= ST_PACK;
                end
                ST_PACK: begin
                    result_q <= flt;
                    fixed_q  <= z_fin;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.result         = result_q;
    assign bus.fixedpoint_out = fixed_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed and random atan2 checks of cordic_vectoring against a real-arithmetic reference.
module tb_cordic_vectoring;

    localparam int  M   = 22;
    localparam int  LAT = M + 2;
    localparam real TOL = 1.0 / 65536.0;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cordic_vectoring_if bus ();

    cordic_vectoring #(.M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bits(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_real(input string tag, input real got, input real exp);
        logic ok;
        checks++;
        ok = ((got - exp) <= TOL) && ((exp - got) <= TOL);
        assert (ok === 1'b1) else begin
            failures++;
            $error("FAIL %s got=%f expected=%f", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return f[31] ? -m : m;
    endfunction

    // Operand value after the unit's float->Q1.24 conversion rules
    function automatic real fix_val(input logic [31:0] f);
        real m;
        int  e;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        if (e == 255 || m >= 2.0)
            m = 2.0 - 1.0 / 16777216.0;
        else
            m = $floor(m * 16777216.0) / 16777216.0;
        return f[31] ? -m : m;
    endfunction

    function automatic real model(input logic [31:0] a, input logic [31:0] b);
        real x, y;
        x = fix_val(a);
        y = fix_val(b);
        if (x == 0.0 && y == 0.0) return 0.0;
        return $atan2(y, x);
    endfunction

    function automatic logic [31:0] rnd_float();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(125, 127)), 23'($urandom)};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.dataa = a;
        bus.datab = b;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; pulse_at >= 0 injects a start while busy
    task automatic wait_done(input int pulse_at, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            bus.start = (n == pulse_at);
            if (n == pulse_at) begin
                bus.dataa = 32'hBF800000;
                bus.datab = 32'h00000000;
            end
            tick();
            n++;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        real exp;
        exp = model(a, b);
        chk_real({tag, "_result"}, f2r(bus.result), exp);
        chk_real({tag, "_fixed"}, real'($signed(bus.fixedpoint_out)) / 16777216.0, exp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int n;
        issue(a, b);
        wait_done(-1, n);
        chk_bits({tag, "_latency"}, 64'(n), 64'(LAT));
        check_op(tag, a, b);
    endtask

    initial begin
        int          n;
        int          extra;
        logic [31:0] ra, rb;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.dataa = '0;
        bus.datab = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk_bits("reset_busy", 64'(bus.busy), 64'd0);
        chk_bits("reset_done", 64'(bus.done), 64'd0);
        chk_bits("reset_result", 64'(bus.result), 64'd0);
        chk_bits("reset_fixed", 64'(bus.fixedpoint_out), 64'd0);

        issue(32'h3F800000, 32'h3F800000);
        chk_bits("q1_busy_accept", 64'(bus.busy), 64'd1);
        wait_done(-1, n);
        chk_bits("q1_latency", 64'(n), 64'(LAT));
        chk_bits("q1_busy_at_done", 64'(bus.busy), 64'd0);
        check_op("q1", 32'h3F800000, 32'h3F800000);
        tick();
        chk_bits("q1_done_pulse", 64'(bus.done), 64'd0);
        chk_bits("q1_busy_after", 64'(bus.busy), 64'd0);

        run_op("pos_y_axis", 32'h00000000, 32'h3F800000);
        run_op("neg_x_axis", 32'hBF800000, 32'h00000000);
        run_op("q4", 32'h3F800000, 32'hBF800000);
        run_op("q3", 32'hBF800000, 32'hBF800000);
        run_op("q2", 32'hBF000000, 32'h3F400000);

        issue(32'h00000000, 32'h00000000);
        wait_done(-1, n);
        chk_bits("zero_latency", 64'(n), 64'(LAT));
        chk_bits("zero_result", 64'(bus.result), 64'd0);
        chk_bits("zero_fixed", 64'(bus.fixedpoint_out), 64'd0);

        issue(32'h41200000, 32'h41200000);
        wait_done(5, n);
        chk_bits("sat_latency", 64'(n), 64'(LAT));
        check_op("sat", 32'h41200000, 32'h41200000);
        extra = 0;
        repeat (30) begin
            tick();
            if (bus.done === 1'b1) extra++;
        end
        chk_bits("sat_single_done", 64'(extra), 64'd0);

        run_op("inf_x", 32'h7F800000, 32'h3F000000);

        issue(32'h3F800000, 32'h3F000000);
        wait_done(-1, n);
        check_op("b2b_first", 32'h3F800000, 32'h3F000000);
        issue(32'hBF400000, 32'hBE800000);
        chk_bits("b2b_accept_busy", 64'(bus.busy), 64'd1);
        wait_done(-1, n);
        chk_bits("b2b_latency", 64'(n), 64'(LAT));
        check_op("b2b_second", 32'hBF400000, 32'hBE800000);

        for (int r = 0; r < 16; r++) begin
            ra = rnd_float();
            rb = rnd_float();
            run_op($sformatf("rand%0d", r), ra, rb);
        end

        issue(32'h3F800000, 32'h3F800000);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bits("abort_busy", 64'(bus.busy), 64'd0);
        chk_bits("abort_done", 64'(bus.done), 64'd0);
        chk_bits("abort_result", 64'(bus.result), 64'd0);
        chk_bits("abort_fixed", 64'(bus.fixedpoint_out), 64'd0);
        extra = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) extra++;
        end
        chk_bits("abort_no_done", 64'(extra), 64'd0);

        run_op("after_abort", 32'h3F800000, 32'hBF000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
